// File: rtl/tlc_phase_arbiter_if.sv
// ---------------------------------------------------------------------------
// tlc_phase_arbiter_if
//
// Signal bundle between the phase arbiter and its environment.
//   ena      : 1 = normal sequencing, 0 = flash mode
//   req[3:0] : per-approach vehicle sensors (level)
//   peak     : peak-hour flag, sampled when an approach enters green
//   tl[7:0]  : light codes, approach i on tl[2i+1:2i] (00 red, 01 yellow, 10 green)
//   grant    : index of the approach owning the right-of-way
//   busy     : high during yellow and all-red clearance
// With TLC_PED_EN defined the bundle also carries ped_req / ped_walk.
//
// Modports: master = environment (drives requests), slave = arbiter.
// ---------------------------------------------------------------------------
interface tlc_phase_arbiter_if;
    logic       ena;
    logic [3:0] req;
    logic       peak;
    logic [7:0] tl;
    logic [1:0] grant;
    logic       busy;
`ifdef TLC_PED_EN
    logic       ped_req;
    logic       ped_walk;

    modport master (
        output ena, req, peak, ped_req,
        input  tl, grant, busy, ped_walk
    );

    modport slave (
        input  ena, req, peak, ped_req,
        output tl, grant, busy, ped_walk
    );
`else
    modport master (
        output ena, req, peak,
        input  tl, grant, busy
    );

    modport slave (
        input  ena, req, peak,
        output tl, grant, busy
    );
`endif
endinterface

// File: rtl/tlc_phase_arbiter.sv
// ---------------------------------------------------------------------------
// tlc_phase_arbiter
//
// Round-robin right-of-way scheduler for a four-approach intersection.
// Each granted approach runs GREEN (min/max green, max extended when the
// peak flag is set on entry), then YELLOW, then an ALLRED clearance before
// the next pending approach is granted. ena=0 forces flash mode; leaving
// flash goes through ALLRED and restarts at approach 0.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : tlc_phase_arbiter_if.slave (ena, req, peak in; tl, grant, busy out)
//
// Optional feature macro: TLC_PED_EN
//   Adds ped_req / ped_walk on the interface, parameter PED_T and a PED
//   walk phase that takes priority over vehicle grants at ALLRED exit.
// ---------------------------------------------------------------------------
module tlc_phase_arbiter #(
    parameter int TICK_DIV       = 50_000_000,
    parameter int TIMER_W        = 8,
    parameter int MIN_GREEN      = 5,
    parameter int MAX_GREEN      = 30,
    parameter int PEAK_MAX_GREEN = 60,
    parameter int YELLOW_T       = 3,
    parameter int ALLRED_T       = 2
`ifdef TLC_PED_EN
    ,
    parameter int PED_T          = 10
`endif
) (
    input  logic                clk,
    input  logic                reset,
    tlc_phase_arbiter_if.slave  bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    // Durations widened by one bit so elapsed = timer+1 never overflows.
    localparam logic [TIMER_W:0]   MIN_W  = (TIMER_W + 1)'(MIN_GREEN);
    localparam logic [TIMER_W:0]   YEL_W  = (TIMER_W + 1)'(YELLOW_T);
    localparam logic [TIMER_W:0]   AR_W   = (TIMER_W + 1)'(ALLRED_T);
    localparam logic [TIMER_W-1:0] MAX_T  = TIMER_W'(MAX_GREEN);
    localparam logic [TIMER_W-1:0] PEAK_T = TIMER_W'(PEAK_MAX_GREEN);
`ifdef TLC_PED_EN
    localparam logic [TIMER_W:0]   PED_W  = (TIMER_W + 1)'(PED_T);
`endif

    typedef enum logic [2:0] {
        ST_GREEN,
        ST_YELLOW,
        ST_ALLRED,
`ifdef TLC_PED_EN
        ST_PED,
`endif
        ST_FLASH
    } state_t;

    state_t             state_reg, state_next;
    logic [1:0]         grant_reg, grant_next;
    logic [7:0]         tl_reg, tl_next;
    logic               busy_reg, busy_next;
    logic [3:0]         pending_reg, pending_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic [TIMER_W-1:0] max_eff_reg, max_eff_next;
    logic [PW-1:0]      presc_reg, presc_next;
    // Set when leaving flash: the following ALLRED exit restarts at approach 0.
    logic               recover_reg, recover_next;

    logic               tick;
    logic [TIMER_W:0]   elapsed;
    logic [TIMER_W:0]   green_elapsed;
    logic [TIMER_W-1:0] timer_sat;
    logic [3:0]         grant_mask;
    logic               others;
    logic               enter_green;
    logic               flash_any;
    logic [1:0]         rr_next;

`ifdef TLC_PED_EN
    logic               ped_pending_reg, ped_pending_next;
    logic               ped_walk_reg, ped_walk_next;
`endif

    assign tick          = (presc_reg == TICK_LAST);
    assign elapsed       = {1'b0, timer_reg} + (TIMER_W + 1)'(1);
    assign green_elapsed = (elapsed > {1'b0, max_eff_reg}) ? {1'b0, max_eff_reg} : elapsed;
    assign timer_sat     = (timer_reg == {TIMER_W{1'b1}}) ? timer_reg : elapsed[TIMER_W-1:0];
    assign grant_mask    = 4'b0001 << grant_reg;
    assign flash_any     = (state_reg == ST_FLASH) || (state_next == ST_FLASH);

`ifdef TLC_PED_EN
    assign others = (|(pending_reg & ~grant_mask)) | ped_pending_reg;
`else
    assign others = |(pending_reg & ~grant_mask);
`endif

    // Round-robin search grant+1, grant+2, grant+3; descending loop so the
    // nearest pending approach is the last (winning) assignment.
    always_comb begin
        rr_next = grant_reg;
        for (int k = 3; k >= 1; k--) begin
            if (pending_reg[grant_reg + 2'(k)]) begin
                rr_next = grant_reg + 2'(k);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        timer_next   = timer_reg;
        presc_next   = tick ? '0 : presc_reg + PW'(1);
        max_eff_next = max_eff_reg;
        recover_next = recover_reg;
        enter_green  = 1'b0;

        if (!bus.ena) begin
            state_next = ST_FLASH;
        end else begin
            case (state_reg)
                ST_GREEN: begin
                    if (tick) begin
                        timer_next = green_elapsed[TIMER_W-1:0];
                        if (others && (green_elapsed >= MIN_W) &&
                            (!bus.req[grant_reg] || (green_elapsed >= {1'b0, max_eff_reg}))) begin
                            state_next = ST_YELLOW;
                        end
                    end
                end
                ST_YELLOW: begin
                    if (tick) begin
                        timer_next = timer_sat;
                        if (elapsed >= YEL_W) begin
                            state_next = ST_ALLRED;
                        end
                    end
                end
                ST_ALLRED: begin
                    if (tick) begin
                        timer_next = timer_sat;
                        if (elapsed >= AR_W) begin
`ifdef TLC_PED_EN
                            if (ped_pending_reg) begin
                                state_next = ST_PED;
                            end else begin
                                enter_green = 1'b1;
                            end
`else
                            enter_green = 1'b1;
`endif
                        end
                    end
                end
`ifdef TLC_PED_EN
                ST_PED: begin
                    if (tick) begin
                        timer_next = timer_sat;
                        if (elapsed >= PED_W) begin
                            state_next = ST_ALLRED;
                        end
                    end
                end
`endif
                ST_FLASH: begin
                    state_next   = ST_ALLRED;
                    recover_next = 1'b1;
                end
                default: begin
                    state_next = ST_GREEN;
                end
            endcase

            if (enter_green) begin
                state_next   = ST_GREEN;
                grant_next   = recover_reg ? 2'd0 : rr_next;
                recover_next = 1'b0;
                max_eff_next = bus.peak ? PEAK_T : MAX_T;
            end
        end

        // Every state starts its duration from a fresh tick boundary.
        if (state_next != state_reg) begin
            presc_next = '0;
            timer_next = '0;
        end
    end

    assign busy_next = (state_next == ST_YELLOW) || (state_next == ST_ALLRED);

    // Per-approach light code and pending latch. A clear (approach enters
    // green, or flash) overrides a simultaneous set.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic pend_set;
        logic pend_clr;

        assign pend_set = bus.req[gi] && (grant_reg != 2'(gi)) && (state_reg != ST_FLASH);
        assign pend_clr = flash_any || (enter_green && (grant_next == 2'(gi)));
        assign pending_next[gi] = pend_clr ? 1'b0 : (pending_reg[gi] | pend_set);

        assign tl_next[2*gi +: 2] =
            (state_next == ST_FLASH)       ? 2'b01 :
            (grant_next != 2'(gi))         ? 2'b00 :
            (state_next == ST_GREEN)       ? 2'b10 :
            (state_next == ST_YELLOW)      ? 2'b01 : 2'b00;
    end

`ifdef TLC_PED_EN
    always_comb begin
        ped_pending_next = ped_pending_reg;
        if (flash_any || ((state_next == ST_PED) && (state_reg != ST_PED))) begin
            ped_pending_next = 1'b0;
        end else if (bus.ped_req) begin
            ped_pending_next = 1'b1;
        end
    end

    assign ped_walk_next = (state_next == ST_PED);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_GREEN;
            grant_reg       <= 2'd0;
            tl_reg          <= 8'h02;
            busy_reg        <= 1'b0;
            pending_reg     <= 4'b0000;
            timer_reg       <= '0;
            presc_reg       <= '0;
            max_eff_reg     <= MAX_T;
            recover_reg     <= 1'b0;
`ifdef TLC_PED_EN
            ped_pending_reg <= 1'b0;
            ped_walk_reg    <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            tl_reg          <= tl_next;
            busy_reg        <= busy_next;
            pending_reg     <= pending_next;
            timer_reg       <= timer_next;
            presc_reg       <= presc_next;
            max_eff_reg     <= max_eff_next;
            recover_reg     <= recover_next;
`ifdef TLC_PED_EN
            ped_pending_reg <= ped_pending_next;
            ped_walk_reg    <= ped_walk_next;
`endif
        end
    end

    assign bus.tl    = tl_reg;
    assign bus.grant = grant_reg;
    assign bus.busy  = busy_reg;
`ifdef TLC_PED_EN
    assign bus.ped_walk = ped_walk_reg;
`endif

endmodule

// File: tb/tb_tlc_phase_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tlc_phase_arbiter
//
// Directed bench for tlc_phase_arbiter with TICK_DIV=4, MIN=2, MAX=5,
// PEAK_MAX=8, YELLOW=2, ALLRED=1 (PED_T=3 when TLC_PED_EN is defined).
// Expected values are queued before each step and popped when the DUT
// output is sampled (negedge, or mid-cycle for async reset checks).
// ---------------------------------------------------------------------------
module tb_tlc_phase_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    tlc_phase_arbiter_if bus();

    tlc_phase_arbiter #(
        .TICK_DIV       (4),
        .TIMER_W        (8),
        .MIN_GREEN      (2),
        .MAX_GREEN      (5),
        .PEAK_MAX_GREEN (8),
        .YELLOW_T       (2),
        .ALLRED_T       (1)
`ifdef TLC_PED_EN
        ,
        .PED_T          (3)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL sb_empty: observed %0h with no expectation queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
            $display("check %-22s observed %0h expected %0h", e.tag, obs, e.val);
        end
    endtask

    // Advance negedges until tl matches, at most max_cyc steps.
    task automatic wait_tl(input logic [7:0] target, input int max_cyc, output int lat);
        lat = 0;
        while ((bus.tl !== target) && (lat < max_cyc)) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Count consecutive negedge samples (including the current one) with tl == target.
    task automatic dur_tl(input logic [7:0] target, input int max_cyc, output int n);
        n = 0;
        while ((bus.tl === target) && (n < max_cyc)) begin
            n++;
            @(negedge clk);
        end
    endtask

`ifdef TLC_PED_EN
    task automatic dur_walk(input logic walk, input int max_cyc, output int n);
        n = 0;
        while ((bus.tl === 8'h00) && (bus.ped_walk === walk) && (n < max_cyc)) begin
            n++;
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         n;
        logic [7:0] pat;

        bus.ena  = 1'b1;
        bus.req  = 4'b0000;
        bus.peak = 1'b0;
`ifdef TLC_PED_EN
        bus.ped_req = 1'b0;
`endif
        reset = 1'b0;

        // Reset state
        expect_val("rst_tl", 32'h02);
        expect_val("rst_grant", 32'd0);
        expect_val("rst_busy", 32'd0);
        repeat (3) @(negedge clk);
        compare(32'(bus.tl));
        compare(32'(bus.grant));
        compare(32'(bus.busy));

        // Approaches 0 and 1 both held: max green each, peak extends next entry
        bus.req = 4'b0011;
        reset   = 1'b1;
        expect_val("t3_green0_cycles", 32'd20);
        dur_tl(8'h02, 100, n);
        compare(32'(n));
        expect_val("t3_yellow0_cycles", 32'd8);
        dur_tl(8'h01, 40, n);
        compare(32'(n));
        expect_val("t3_allred_cycles", 32'd4);
        dur_tl(8'h00, 40, n);
        compare(32'(n));
        expect_val("t3_green1_tl", 32'h08);
        expect_val("t3_green1_grant", 32'd1);
        compare(32'(bus.tl));
        compare(32'(bus.grant));
        bus.peak = 1'b1;
        expect_val("t3_green1_cycles", 32'd20);
        dur_tl(8'h08, 100, n);
        compare(32'(n));
        expect_val("t3_yellow1_cycles", 32'd8);
        dur_tl(8'h04, 40, n);
        compare(32'(n));
        expect_val("t3_allred1_cycles", 32'd4);
        dur_tl(8'h00, 40, n);
        compare(32'(n));
        expect_val("t3_peak_green0_cycles", 32'd32);
        dur_tl(8'h02, 100, n);
        compare(32'(n));
        expect_val("t3_yellow_busy", 32'd1);
        compare(32'(bus.busy));

        // Asynchronous reset mid-yellow, then long idle
        #2 reset = 1'b0;
        #1;
        expect_val("t1_async_tl", 32'h02);
        expect_val("t1_async_grant", 32'd0);
        expect_val("t1_async_busy", 32'd0);
        compare(32'(bus.tl));
        compare(32'(bus.grant));
        compare(32'(bus.busy));
        repeat (3) @(negedge clk);
        bus.req  = 4'b0000;
        bus.peak = 1'b0;
        reset    = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if ((bus.tl !== 8'h02) || (bus.grant !== 2'd0) || (bus.busy !== 1'b0)) begin
                n++;
            end
            @(negedge clk);
        end
        expect_val("t1_idle_bad_cycles", 32'd0);
        compare(32'(n));

        // Single-cycle pulse on req[2] after idle
        bus.req = 4'b0100;
        @(negedge clk);
        bus.req = 4'b0000;
        wait_tl(8'h01, 8, lat);
        expect_val("t2_yellow_tl", 32'h01);
        compare(32'(bus.tl));
        expect_val("t2_latency_le4", 32'd1);
        compare(32'(lat <= 4));
        expect_val("t2_yellow_cycles", 32'd8);
        dur_tl(8'h01, 40, n);
        compare(32'(n));
        expect_val("t2_allred_cycles", 32'd4);
        dur_tl(8'h00, 40, n);
        compare(32'(n));
        expect_val("t2_green2_tl", 32'h20);
        expect_val("t2_green2_grant", 32'd2);
        expect_val("t2_green2_busy", 32'd0);
        compare(32'(bus.tl));
        compare(32'(bus.grant));
        compare(32'(bus.busy));

        // Round-robin order 1,2,3 from a simultaneous pulse, then rest on 3
        reset = 1'b0;
        repeat (2) @(negedge clk);
        bus.req = 4'b1110;
        reset   = 1'b1;
        @(negedge clk);
        bus.req = 4'b0000;
        for (int g = 1; g < 4; g++) begin
            pat = 8'h02 << (2 * g);
            wait_tl(pat, 60, lat);
            expect_val($sformatf("t4_rr%0d_tl", g), 32'(pat));
            expect_val($sformatf("t4_rr%0d_grant", g), 32'(g));
            compare(32'(bus.tl));
            compare(32'(bus.grant));
        end
        expect_val("t4_rest3_cycles", 32'd100);
        dur_tl(8'h80, 100, n);
        compare(32'(n));
        bus.req = 4'b0011;
        @(negedge clk);
        bus.req = 4'b0000;
        wait_tl(8'h02, 60, lat);
        expect_val("t4_wrap_tl", 32'h02);
        expect_val("t4_wrap_grant", 32'd0);
        compare(32'(bus.tl));
        compare(32'(bus.grant));

        // Flash during yellow of approach 1; recovery restarts at approach 0
        wait_tl(8'h08, 60, lat);
        expect_val("t5_green1_tl", 32'h08);
        expect_val("t5_green1_grant", 32'd1);
        compare(32'(bus.tl));
        compare(32'(bus.grant));
        bus.req = 4'b0100;
        @(negedge clk);
        bus.req = 4'b0000;
        wait_tl(8'h04, 10, lat);
        expect_val("t5_yellow1_tl", 32'h04);
        expect_val("t5_yellow1_busy", 32'd1);
        compare(32'(bus.tl));
        compare(32'(bus.busy));
        bus.ena = 1'b0;
        @(negedge clk);
        expect_val("t5_flash_tl", 32'h55);
        expect_val("t5_flash_grant", 32'd1);
        expect_val("t5_flash_busy", 32'd0);
        compare(32'(bus.tl));
        compare(32'(bus.grant));
        compare(32'(bus.busy));
        bus.req = 4'b1000;
        repeat (5) @(negedge clk);
        bus.req = 4'b0000;
        expect_val("t5_flash_hold_tl", 32'h55);
        compare(32'(bus.tl));
        bus.ena = 1'b1;
        @(negedge clk);
        expect_val("t5_recover_allred_cycles", 32'd4);
        dur_tl(8'h00, 20, n);
        compare(32'(n));
        expect_val("t5_recover_tl", 32'h02);
        expect_val("t5_recover_grant", 32'd0);
        compare(32'(bus.tl));
        compare(32'(bus.grant));
        expect_val("t5_pending_cleared_rest", 32'd60);
        dur_tl(8'h02, 60, n);
        compare(32'(n));

        // Reset asserted in the middle of ALLRED
        bus.req = 4'b0010;
        @(negedge clk);
        bus.req = 4'b0000;
        wait_tl(8'h01, 10, lat);
        expect_val("t5_yellow0_tl", 32'h01);
        compare(32'(bus.tl));
        wait_tl(8'h00, 12, lat);
        expect_val("t5_allred_tl", 32'h00);
        expect_val("t5_allred_busy", 32'd1);
        compare(32'(bus.tl));
        compare(32'(bus.busy));
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        expect_val("t5_rst_allred_tl", 32'h02);
        expect_val("t5_rst_allred_busy", 32'd0);
        compare(32'(bus.tl));
        compare(32'(bus.busy));
        repeat (2) @(negedge clk);
        reset = 1'b1;

`ifdef TLC_PED_EN
        // Pedestrian phase preempts the next vehicle grant
        bus.req = 4'b0010;
        @(negedge clk);
        bus.req = 4'b0000;
        wait_tl(8'h08, 60, lat);
        expect_val("t6_green1_tl", 32'h08);
        compare(32'(bus.tl));
        bus.ped_req = 1'b1;
        bus.req     = 4'b1000;
        @(negedge clk);
        bus.ped_req = 1'b0;
        bus.req     = 4'b0000;
        wait_tl(8'h04, 20, lat);
        expect_val("t6_yellow1_tl", 32'h04);
        compare(32'(bus.tl));
        expect_val("t6_yellow1_cycles", 32'd8);
        dur_tl(8'h04, 40, n);
        compare(32'(n));
        expect_val("t6_allred_pre_cycles", 32'd4);
        dur_walk(1'b0, 40, n);
        compare(32'(n));
        expect_val("t6_walk_cycles", 32'd12);
        dur_walk(1'b1, 40, n);
        compare(32'(n));
        expect_val("t6_allred_post_cycles", 32'd4);
        dur_walk(1'b0, 40, n);
        compare(32'(n));
        expect_val("t6_next_tl", 32'h80);
        expect_val("t6_next_grant", 32'd3);
        expect_val("t6_next_walk", 32'd0);
        compare(32'(bus.tl));
        compare(32'(bus.grant));
        compare(32'(bus.ped_walk));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tlc_phase_arbiter.md
Name: tlc_phase_arbiter

Overview:
Sensor-driven phase scheduler for a four-approach intersection. It shares one right-of-way between four approach requesters using round-robin order. Each approach gets min/max green, then yellow, then an all-red clearance. It drives the 2-bit light codes consumed by the TLC light outputs, and the peak flag from the time-of-day logic selects the extended max-green.

Parameters:
TICK_DIV, 50_000_000, clk cycles per timing tick (1 s at 50 MHz); must be >= 2
TIMER_W, 8, width of tick timer
MIN_GREEN, 5, minimum green in ticks (>=1)
MAX_GREEN, 30, off-peak max green in ticks (>= MIN_GREEN)
PEAK_MAX_GREEN, 60, peak max green in ticks (>= MIN_GREEN)
YELLOW_T, 3, yellow duration in ticks (>=1)
ALLRED_T, 2, all-red clearance in ticks (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low; 0 = reset
ena  in  1  1 = normal operation; 0 = flash mode
req  in  4  per-approach vehicle sensor, level, synchronous to clk
peak  in  1  peak-hour flag, sampled on GREEN entry
tl  out  8  light codes, approach i on tl[2i+1:2i]; 00 red, 01 yellow, 10 green
grant  out  2  index of approach currently owning right-of-way
busy  out  1  1 in YELLOW or ALLRED

Behaviour:
- Reset (reset=0, immediate): state GREEN, grant=0, tl=8'h02, busy=0, pending=0, timer=0, prescaler=0, max_eff=MAX_GREEN.
- Tick: prescaler counts 0..TICK_DIV-1 and tick=1 when it equals TICK_DIV-1. Prescaler and timer are cleared on every state transition, so each state lasts exactly N*TICK_DIV cycles.
- Pending latch: pending[i] is set when req[i]=1 and i != grant, and is held until approach i enters GREEN.
  - req[grant] is never latched.
  - If a set and a clear hit the same cycle, the clear wins.
- GREEN(grant):
  - On each tick, elapsed = timer+1, saturating at max_eff.
  - Exit to YELLOW on the tick where others = |pending (excluding grant) and elapsed >= MIN_GREEN and (req[grant]=0 or elapsed >= max_eff).
  - With no other pending request, green rests indefinitely.
- YELLOW: tl[grant]=01, others red; after YELLOW_T ticks go to ALLRED.
- ALLRED: tl=0; after ALLRED_T ticks pick the next grant.
  - Next grant is the first set pending bit searching grant+1, grant+2, grant+3 (mod 4).
  - If none is set (pending cleared by a flash exit), next grant = current grant.
  - Enter GREEN: clear pending[next], sample peak into max_eff (PEAK_MAX_GREEN if 1, else MAX_GREEN).
- FLASH: entered from any state the cycle after ena is seen low.
  - tl=8'h55; grant held; pending cleared and not latched while in FLASH.
  - On ena=1, go to ALLRED for ALLRED_T ticks, then GREEN with grant=0.
- tl, grant and busy are registered, and update on the same edge as the state change.
- Timer saturates and never wraps. No arithmetic overflow is permitted for TIMER_W >= clog2(max(PEAK_MAX_GREEN, ALLRED_T, YELLOW_T)+1).

Optional Feature:
TLC_PED_EN
- Adds input ped_req (1) and output ped_walk (1), plus parameter PED_T (default 10).
- ped_req latches ped_pending. At ALLRED exit, ped_pending has priority over vehicle grants.
- State PED: tl=0, ped_walk=1 for PED_T ticks; ped_pending is cleared on entry. PED then goes to ALLRED and resumes round-robin from the unchanged grant.
- ped_pending is also "others pending" in GREEN. FLASH clears it.
- Without the macro: ports, state and logic are absent, and behaviour is exactly as above.

Test Plan:
All scenarios use TICK_DIV=4, MIN=2, MAX=5, PEAK_MAX=8, YELLOW=2, ALLRED=1.
1. Reset low for 3 cycles mid-operation, then release with req=0 for 200 cycles -> tl=8'h02, grant=0, busy=0 throughout.
2. After 40 idle cycles, 1-cycle pulse on req[2] (req[0]=0) -> tl=8'h01 on the next tick edge (<=4 cycles); 8 cycles later tl=8'h00; 4 cycles later tl=8'h20, grant=2.
3. From reset, req[0]=1 and req[1]=1 held, peak=0 -> approach 0 green for exactly 20 cycles; repeat with peak=1 -> 32 cycles.
4. During green 0, pulse req[3], req[1], req[2] together -> grants in order 1,2,3, then green rests on 3. Then pulse req[0] and req[1] -> grant 0 next.
5. ena=0 during YELLOW -> tl=8'h55 the next cycle, pending cleared. ena=1 -> tl=8'h00 for 4 cycles, then tl=8'h02. Reset asserted mid-ALLRED -> tl=8'h02 immediately.
6. (TLC_PED_EN, PED_T=3) ped_req pulse during green 1 -> after yellow and all-red, ped_walk=1 and tl=0 for 12 cycles; then all-red 4 cycles, then next vehicle grant.
